// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: parallel word in, start/data/stop serial frame out
//
// Frames each accepted word as a start bit, DataBits data bits LSB first,
// an optional even-parity bit and StopBits stop bits. Every bit boundary
// is paced by the shared baud generator's bit_trigger pulse.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit is sent between the data and stop bits.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   bit_trigger  in   1-clk pulse, once per bit period
//   data         in   word to transmit, sampled only on accept
//   data_valid   in   upstream has a word
//   data_ready   out  block can accept a word (high only in IDLE)
//   tx           out  serial line, idle high, registered
//   busy         out  high from accept until the frame completes

module uart_tx #(
  parameter int DataBits = 8,
  parameter int StopBits = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_trigger,
  input  logic [DataBits-1:0] data,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                tx,
  output logic                busy
);

  localparam int CntW = (DataBits > 1) ? $clog2(DataBits) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, LOADED, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LOADED, START, DATA, STOP
  } state_t;
`endif

  state_t              state;
  logic [DataBits-1:0] shift;
  logic [CntW-1:0]     cnt;
`ifdef UART_TX_PARITY_EN
  logic                parity_bit;
`endif

  // The frame is released back to IDLE on the trigger that launches the
  // final stop bit. The idle line level keeps that bit on the wire for the
  // rest of its period, so a word queued behind this one starts exactly one
  // bit time later with no extra idle bit in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      data_ready <= 1'b1;
      busy       <= 1'b0;
      cnt        <= '0;
      shift      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // data_ready is always high here, so valid alone means accept.
          // A trigger in the accept cycle is deliberately not acted on.
          if (data_valid) begin
            shift      <= data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data;
`endif
            data_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= LOADED;
          end
        end

        LOADED: begin
          if (bit_trigger) begin
            tx    <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (bit_trigger) begin
            tx    <= shift[0];
            shift <= shift >> 1;
            cnt   <= '0;
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_trigger) begin
            if (cnt == CntW'(DataBits - 1)) begin
              cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx <= 1'b1;
              if (StopBits == 1) begin
                data_ready <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
              end else begin
                state <= STOP;
              end
`endif
            end else begin
              tx    <= shift[0];
              shift <= shift >> 1;
              cnt   <= cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_trigger) begin
            tx <= 1'b1;
            if (StopBits == 1) begin
              data_ready <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= STOP;
            end
          end
        end
`endif

        // Only reached when more than one stop bit is configured; counts the
        // stop bits before the last one.
        STOP: begin
          if (bit_trigger) begin
            if (int'(cnt) >= StopBits - 2) begin
              cnt        <= '0;
              data_ready <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          tx         <= 1'b1;
          data_ready <= 1'b1;
          busy       <= 1'b0;
          cnt        <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (table vectors plus bit scoreboard)

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int STOP_BITS = 2;
  localparam int FRAME_N   = 12;
`else
  localparam int STOP_BITS = 1;
  localparam int FRAME_N   = 10;
`endif
  localparam int NV = 6;

  typedef struct {
    logic [7:0]  d;
    bit          b2b;   // valid held high from the previous vector
    logic [15:0] exp;   // transmitted bits, bit 0 goes out first
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_trigger = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       tx;
  logic       busy;

  int   nvec = 0;
  int   nerr = 0;
  logic sb[$];
  bit   trig_en = 1'b0;
  int   tcnt = 0;
  int   acc = 0;
  logic busy_q = 1'b0;

  uart_tx #(.DataBits(8), .StopBits(STOP_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_trigger(bit_trigger),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [7:0] d);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  // Baud pulse every 4 clocks while enabled.
  initial forever begin
    @(negedge clk);
    tcnt++;
    if (trig_en) bit_trigger = (tcnt % 4 == 0);
  end

  // Each trigger edge that falls inside an expected frame must put the next
  // scoreboard bit on the line.
  initial begin : tx_mon
    logic e;
    forever begin
      @(posedge clk);
      if (bit_trigger === 1'b1 && rst === 1'b0 && sb.size() > 0) begin
        e = sb.pop_front();
        #1;
        chk("tx_bit", {31'd0, tx}, {31'd0, e});
      end
    end
  end

  // busy only rises on an accept.
  initial forever begin
    @(posedge clk);
    #1;
    if (busy === 1'b1 && busy_q === 1'b0) acc++;
    busy_q = busy;
  end

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && data_ready === 1'b1 && busy === 1'b0) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [7:0] d, input logic [15:0] bits, input int n);
    int k;
    @(negedge clk);
    data       = d;
    data_valid = 1'b1;
    k = 0;
    while (data_ready !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      chk("accept_timeout", 32'd0, 32'd1);
      data_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < n; i++) sb.push_back(bits[i]);
  endtask

  initial begin
    #500000;
    nerr++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    vec_t tbl[NV];
    int   acc0;
    int   k;
    logic t;

`ifdef UART_TX_PARITY_EN
    tbl[0] = '{d: 8'h07, b2b: 1'b0, exp: {4'd0, 2'b11, 1'b1, 8'h07, 1'b0}};
    tbl[1] = '{d: 8'h03, b2b: 1'b0, exp: {4'd0, 2'b11, 1'b0, 8'h03, 1'b0}};
    tbl[2] = '{d: 8'hA3, b2b: 1'b0, exp: {4'd0, 2'b11, 1'b0, 8'hA3, 1'b0}};
    tbl[3] = '{d: 8'h0F, b2b: 1'b1, exp: {4'd0, 2'b11, 1'b0, 8'h0F, 1'b0}};
    tbl[4] = '{d: 8'h80, b2b: 1'b0, exp: {4'd0, 2'b11, 1'b1, 8'h80, 1'b0}};
    tbl[5] = '{d: 8'h55, b2b: 1'b0, exp: {4'd0, 2'b11, 1'b0, 8'h55, 1'b0}};
`else
    tbl[0] = '{d: 8'h55, b2b: 1'b0, exp: {6'd0, 1'b1, 8'h55, 1'b0}};
    tbl[1] = '{d: 8'hA3, b2b: 1'b0, exp: {6'd0, 1'b1, 8'hA3, 1'b0}};
    tbl[2] = '{d: 8'h0F, b2b: 1'b1, exp: {6'd0, 1'b1, 8'h0F, 1'b0}};
    tbl[3] = '{d: 8'h00, b2b: 1'b0, exp: {6'd0, 1'b1, 8'h00, 1'b0}};
    tbl[4] = '{d: 8'h80, b2b: 1'b0, exp: {6'd0, 1'b1, 8'h80, 1'b0}};
    tbl[5] = '{d: 8'h01, b2b: 1'b0, exp: {6'd0, 1'b1, 8'h01, 1'b0}};
`endif

    // Reset and idle hold
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out", {29'd0, tx, data_ready, busy}, 32'b110);
    rst     = 1'b0;
    trig_en = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("idle_out", {29'd0, tx, data_ready, busy}, 32'b110);
    end

    // Table vectors, including one back-to-back pair
    acc0 = acc;
    for (int i = 0; i < NV; i++) begin
      if (!tbl[i].b2b) wait_idle("pre_vec");
      send_word(tbl[i].d, tbl[i].exp, FRAME_N);
      if (!(i + 1 < NV && tbl[i + 1].b2b)) begin
        @(negedge clk);
        data_valid = 1'b0;
      end
    end
    wait_idle("table_drain");
    chk("accept_count", acc - acc0, NV);

    // data_ready/busy stay in frame until the last trigger of the frame
    wait_idle("pre_ready");
    send_word(8'h55, frame_of(8'h55), FRAME_N);
    @(negedge clk);
    data_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 400 && k < FRAME_N; c++) begin
      @(posedge clk);
      t = bit_trigger;
      #1;
      if (t) begin
        k++;
        if (k < FRAME_N) chk("busy_mid", {30'd0, data_ready, busy}, 32'b01);
        else             chk("ready_return", {30'd0, data_ready, busy}, 32'b10);
      end
    end
    if (k < FRAME_N) chk("frame_timeout", k, FRAME_N);

    // Accept in the same cycle as a trigger: that trigger is ignored
    wait_idle("pre_coinc");
    trig_en = 1'b0;
    @(negedge clk);
    bit_trigger = 1'b0;
    @(negedge clk);
    bit_trigger = 1'b1;
    data        = 8'h3C;
    data_valid  = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < FRAME_N; i++) sb.push_back(frame_of(8'h3C)[i]);
    @(negedge clk);
    bit_trigger = 1'b0;
    data_valid  = 1'b0;
    chk("coinc_busy", {31'd0, busy}, 32'd1);
    chk("coinc_tx_hold0", {31'd0, tx}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("coinc_tx_hold", {31'd0, tx}, 32'd1);
    end
    trig_en = 1'b1;
    wait_idle("coinc_drain");

    // Reset in the middle of data bit 3, then a clean frame
    send_word(8'h00, frame_of(8'h00), 5);
    @(negedge clk);
    data_valid = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk("abort_wait_timeout", 32'd0, 32'd1);
    chk("abort_pre_tx", {31'd0, tx}, 32'd0);
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", {29'd0, tx, data_ready, busy}, 32'b110);
    send_word(8'hFF, frame_of(8'hFF), FRAME_N);
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle("after_abort");
    chk("final_idle", {29'd0, tx, data_ready, busy}, 32'b110);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
